// File: rtl/stoch_addsub_pkg.sv
// Shared types and helpers for the stochastic signed matrix adder/subtractor.
// Residue range helpers and the saturating clamp used by every element.
package stoch_addsub_pkg;

   typedef enum logic {
      STOCH_ADD = 1'b0,
      STOCH_SUB = 1'b1
   } stoch_mode_t;

   function automatic int cnt_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int cnt_min(input int w);
      return -(1 << (w - 1));
   endfunction

   localparam int CNT_W_DEF = 4;
   localparam int CNT_MAX = cnt_max(CNT_W_DEF);
   localparam int CNT_MIN = cnt_min(CNT_W_DEF);

   function automatic int sat_clamp(input int s, input int w);
      if (s > cnt_max(w)) return cnt_max(w);
      if (s < cnt_min(w)) return cnt_min(w);
      return s;
   endfunction

endpackage

// File: rtl/stoch_signed_addsub_mat_elem.sv
// One matrix element: saturating signed residue counter plus output register.
// Optional sticky SAT flag under STOCH_ADDSUB_SAT_FLAG_EN.
module stoch_signed_addsub_elem
   import stoch_addsub_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   input  logic        mode_clr,
   input  stoch_mode_t mode,
   input  logic        a_p,
   input  logic        a_m,
   input  logic        b_p,
   input  logic        b_m,
   output logic        y_p,
   output logic        y_m
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
   ,
   output logic        sat
`endif
);

   localparam int SW = CNT_W + 2;
   localparam logic signed [SW-1:0] ONE = SW'(1);

   logic signed [CNT_W-1:0] c;
   logic signed [CNT_W-1:0] c_next;
   logic        [1:0]       pos;
   logic        [1:0]       neg;
   logic signed [SW-1:0]    base;
   logic signed [SW-1:0]    s;
   logic signed [SW-1:0]    raw;
   logic                    nxt_p;
   logic                    nxt_m;
   int                      clamped;
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
   logic                    hit;
`endif

   // Net stream sum, residue update and saturation for this element.
   always_comb begin
      pos = {1'b0, a_p} + {1'b0, (mode == STOCH_SUB) ? b_m : b_p};
      neg = {1'b0, a_m} + {1'b0, (mode == STOCH_SUB) ? b_p : b_m};
      // A mode change discards the old residue before this cycle's sum.
      base = mode_clr ? '0 : {{2{c[CNT_W-1]}}, c};
      s = base + signed'({{CNT_W{1'b0}}, pos})
               - signed'({{CNT_W{1'b0}}, neg});
      nxt_p = (s > 0);
      nxt_m = (s < 0);
      raw = '0;
      if (nxt_p) raw = s - ONE;
      else if (nxt_m) raw = s + ONE;
      clamped = sat_clamp(int'(raw), CNT_W);
      c_next = mode_clr ? '0 : CNT_W'(clamped);
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
      hit = !mode_clr && (clamped != int'(raw));
`endif
   end

   // Registered residue and outputs; clear beats advance, stall zeroes outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c   <= '0;
         y_p <= 1'b0;
         y_m <= 1'b0;
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
         sat <= 1'b0;
`endif
      end else if (clr) begin
         c   <= '0;
         y_p <= 1'b0;
         y_m <= 1'b0;
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
         sat <= 1'b0;
`endif
      end else if (en) begin
         c   <= c_next;
         y_p <= nxt_p;
         y_m <= nxt_m;
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
         sat <= sat | hit;
`endif
      end else begin
         y_p <= 1'b0;
         y_m <= 1'b0;
      end
   end

endmodule

// File: rtl/stoch_signed_addsub_mat.sv
// Element-wise stochastic signed matrix Y = A + B / A - B (MODE selects).
// Optional sticky SAT output per element under STOCH_ADDSUB_SAT_FLAG_EN.
module stoch_signed_addsub_mat
   import stoch_addsub_pkg::*;
#(
   parameter int NUM_ROWS = 2,
   parameter int NUM_COLS = 2,
   parameter int CNT_W    = 4
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               EN,
   input  logic                               CLR,
   input  logic                               MODE,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] A_p,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] A_m,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] B_p,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] B_m,
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0] Y_p,
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0] Y_m
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
   ,
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0] SAT
`endif
);

   stoch_mode_t mode_in;
   stoch_mode_t mode_q;
   logic        mode_clr;

   assign mode_in  = stoch_mode_t'(MODE);
   assign mode_clr = EN && !CLR && (mode_in != mode_q);

   // Mode register advances only on real (non-cleared, enabled) cycles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) mode_q <= STOCH_ADD;
      else if (!CLR && EN) mode_q <= mode_in;
   end

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
         stoch_signed_addsub_elem #(
            .CNT_W(CNT_W)
         ) u_elem (
            .clk     (CLK),
            .rst     (RST),
            .en      (EN),
            .clr     (CLR),
            .mode_clr(mode_clr),
            .mode    (mode_in),
            .a_p     (A_p[r][k]),
            .a_m     (A_m[r][k]),
            .b_p     (B_p[r][k]),
            .b_m     (B_m[r][k]),
            .y_p     (Y_p[r][k]),
            .y_m     (Y_m[r][k])
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
            ,
            .sat     (SAT[r][k])
`endif
         );
      end
   end

endmodule

// File: tb/tb_stoch_signed_addsub_mat.sv
// Self-checking bench for stoch_signed_addsub_mat (2x2, CNT_W = 4).
// Directed scenarios plus randomized traffic against an integer model.
module tb_stoch_signed_addsub_mat;

   localparam int R  = 2;
   localparam int C  = 2;
   localparam int CW = 4;
   localparam int MAXV = 2 ** (CW - 1) - 1;
   localparam int MINV = -(2 ** (CW - 1));

   logic clk;
   logic rst;
   logic en;
   logic clr;
   logic mode;
   logic [R-1:0][C-1:0] a_p, a_m, b_p, b_m;
   logic [R-1:0][C-1:0] y_p, y_m;
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
   logic [R-1:0][C-1:0] sat;
`endif

   logic [R-1:0][C-1:0] all1;
   logic [R-1:0][C-1:0] all0;

   int nvec;
   int nerr;

   stoch_signed_addsub_mat #(
      .NUM_ROWS(R),
      .NUM_COLS(C),
      .CNT_W   (CW)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .EN  (en),
      .CLR (clr),
      .MODE(mode),
      .A_p (a_p),
      .A_m (a_m),
      .B_p (b_p),
      .B_m (b_m),
      .Y_p (y_p),
      .Y_m (y_m)
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
      ,
      .SAT (sat)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_in();
      a_p = '0; a_m = '0; b_p = '0; b_m = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0;
      zero_in();
      tick();
      nvec++;
      if ({y_p, y_m} !== {all0, all0}) begin
         nerr++;
         $display("FAIL reset_init: y_p=%h y_m=%h want 0 0", y_p, y_m);
      end
      rst = 1'b0; en = 1'b1;
      a_p = all1; b_p = all1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {all1, all0}) begin
            nerr++;
            $display("FAIL reset_build%0d: y_p=%h y_m=%h want f 0",
                     i, y_p, y_m);
         end
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if ({y_p, y_m} !== {all0, all0}) begin
         nerr++;
         $display("FAIL reset_async: y_p=%h y_m=%h want 0 0", y_p, y_m);
      end
      @(negedge clk);
      rst = 1'b0;
      zero_in();
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {all0, all0}) begin
            nerr++;
            $display("FAIL reset_after%0d: y_p=%h y_m=%h want 0 0",
                     i, y_p, y_m);
         end
      end
   endtask

   task automatic test_add_carry();
      mode = 1'b0;
      a_p = all1; b_p = all1;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) zero_in();
         tick();
         nvec++;
         if ({y_p, y_m} !== {(i < 8) ? all1 : all0, all0}) begin
            nerr++;
            $display("FAIL add_carry%0d: y_p=%h y_m=%h", i, y_p, y_m);
         end
      end
   endtask

   task automatic test_sub_cancel();
      mode = 1'b1;
      a_p = all1; b_p = all1;
      for (int i = 0; i < 10; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {all0, all0}) begin
            nerr++;
            $display("FAIL sub_cancel%0d: y_p=%h y_m=%h want 0 0",
                     i, y_p, y_m);
         end
      end
      zero_in();
      a_m = all1; b_p = all1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) zero_in();
         tick();
         nvec++;
         if ({y_p, y_m} !== {all0, (i < 4) ? all1 : all0}) begin
            nerr++;
            $display("FAIL sub_borrow%0d: y_p=%h y_m=%h", i, y_p, y_m);
         end
      end
   endtask

   task automatic test_saturation();
      mode = 1'b0;
      zero_in();
      tick();
      a_p = all1; b_p = all1;
      for (int i = 0; i < 12; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {all1, all0}) begin
            nerr++;
            $display("FAIL sat_fill%0d: y_p=%h y_m=%h", i, y_p, y_m);
         end
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
         nvec++;
         if (sat !== ((i >= 7) ? all1 : all0)) begin
            nerr++;
            $display("FAIL sat_flag%0d: sat=%h", i, sat);
         end
`endif
      end
      zero_in();
      for (int i = 0; i < MAXV + 2; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {(i < MAXV) ? all1 : all0, all0}) begin
            nerr++;
            $display("FAIL sat_drain%0d: y_p=%h y_m=%h", i, y_p, y_m);
         end
      end
   endtask

   task automatic test_mode_switch();
      mode = 1'b0;
      a_p = all1; b_p = all1;
      for (int i = 0; i < 3; i++) tick();
      zero_in();
      mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {all0, all0}) begin
            nerr++;
            $display("FAIL mode_switch%0d: y_p=%h y_m=%h want 0 0",
                     i, y_p, y_m);
         end
      end
   endtask

   task automatic test_stall_clear();
      mode = 1'b0;
      zero_in();
      tick();
      a_p = all1; b_p = all1;
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_p = R*C'($urandom); a_m = R*C'($urandom);
         b_p = R*C'($urandom); b_m = R*C'($urandom);
         mode = 1'($urandom);
         tick();
         nvec++;
         if ({y_p, y_m} !== {all0, all0}) begin
            nerr++;
            $display("FAIL stall%0d: y_p=%h y_m=%h want 0 0", i, y_p, y_m);
         end
      end
      en = 1'b1; mode = 1'b0;
      zero_in();
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if ({y_p, y_m} !== {(i < 2) ? all1 : all0, all0}) begin
            nerr++;
            $display("FAIL stall_resume%0d: y_p=%h y_m=%h", i, y_p, y_m);
         end
      end
      a_p = all1; b_p = all1;
      tick();
      tick();
      clr = 1'b1;
      tick();
      nvec++;
      if ({y_p, y_m} !== {all0, all0}) begin
         nerr++;
         $display("FAIL clr_cycle: y_p=%h y_m=%h want 0 0", y_p, y_m);
      end
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
      nvec++;
      if (sat !== all0) begin
         nerr++;
         $display("FAIL clr_sat: sat=%h want 0", sat);
      end
`endif
      clr = 1'b0;
      zero_in();
      tick();
      nvec++;
      if ({y_p, y_m} !== {all0, all0}) begin
         nerr++;
         $display("FAIL clr_after: y_p=%h y_m=%h want 0 0", y_p, y_m);
      end
   endtask

   task automatic test_random();
      int mc[R][C];
      int mmode;
      int pos, neg, s, nc;
      bit chg;
      logic [R-1:0][C-1:0] ep, em, es;
      @(negedge clk);
      rst = 1'b1;
      #1 rst = 1'b0;
      mmode = 0;
      ep = '0; em = '0; es = '0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) mc[i][j] = 0;
      for (int t = 0; t < 400; t++) begin
         en  = ($urandom_range(0, 9) < 8);
         clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         a_p = R*C'($urandom); a_m = R*C'($urandom);
         b_p = R*C'($urandom); b_m = R*C'($urandom);
         if (t % 50 < 20) begin
            a_m = '0; b_m = '0;
         end
         @(posedge clk);
         if (clr) begin
            ep = '0; em = '0; es = '0;
            for (int i = 0; i < R; i++)
               for (int j = 0; j < C; j++) mc[i][j] = 0;
         end else if (en) begin
            chg = (int'(mode) != mmode);
            for (int i = 0; i < R; i++)
               for (int j = 0; j < C; j++) begin
                  if (mode) begin
                     pos = a_p[i][j] + b_m[i][j];
                     neg = a_m[i][j] + b_p[i][j];
                  end else begin
                     pos = a_p[i][j] + b_p[i][j];
                     neg = a_m[i][j] + b_m[i][j];
                  end
                  s = (chg ? 0 : mc[i][j]) + pos - neg;
                  ep[i][j] = (s > 0);
                  em[i][j] = (s < 0);
                  nc = (s > 0) ? s - 1 : (s < 0) ? s + 1 : 0;
                  if (chg) nc = 0;
                  if (nc > MAXV) begin
                     nc = MAXV; es[i][j] = 1'b1;
                  end
                  if (nc < MINV) begin
                     nc = MINV; es[i][j] = 1'b1;
                  end
                  mc[i][j] = nc;
               end
            mmode = int'(mode);
         end else begin
            ep = '0; em = '0;
         end
         #1;
         nvec++;
         if ({y_p, y_m} !== {ep, em}) begin
            nerr++;
            $display("FAIL random%0d: y_p=%h y_m=%h want %h %h",
                     t, y_p, y_m, ep, em);
         end
`ifdef STOCH_ADDSUB_SAT_FLAG_EN
         nvec++;
         if (sat !== es) begin
            nerr++;
            $display("FAIL random_sat%0d: sat=%h want %h", t, sat, es);
         end
`else
         if (es === 'x) $display("unreachable");
`endif
      end
      clr = 1'b0; en = 1'b1;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      all1 = '1;
      all0 = '0;
      test_reset();
      test_add_carry();
      test_sub_cancel();
      test_saturation();
      test_mode_switch();
      test_stall_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/stoch_signed_addsub_mat.md
Name: stoch_signed_addsub_mat

Overview:
- Element-wise stochastic signed matrix adder/subtractor with a run-time mode: Y = A + B or Y = A - B. Operands and result are signed bitstream pairs (p/m).
- Each element holds a saturating signed residue counter, so carries and borrows are kept rather than dropped. Exact per-cycle conservation holds until saturation.
- Sits in the stochastic matrix datapath wherever a signed matrix sum or difference is needed. Supersedes the fixed-function subtract-only matrix array.

Parameters:
- NUM_ROWS, 2, matrix rows.
- NUM_COLS, 2, matrix columns.
- CNT_W, 4, residue counter width, signed two's complement. Range -(2^(CNT_W-1)) .. 2^(CNT_W-1)-1. Legal values 3..16.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  advance enable; low = stall.
- CLR  input  1  synchronous clear of all residues and outputs.
- MODE  input  1  0 = add, 1 = subtract.
- A_p  input  [NUM_ROWS][NUM_COLS]  operand A positive streams.
- A_m  input  [NUM_ROWS][NUM_COLS]  operand A negative streams.
- B_p  input  [NUM_ROWS][NUM_COLS]  operand B positive streams.
- B_m  input  [NUM_ROWS][NUM_COLS]  operand B negative streams.
- Y_p  output  [NUM_ROWS][NUM_COLS]  result positive streams, registered.
- Y_m  output  [NUM_ROWS][NUM_COLS]  result negative streams, registered.

Behaviour:
- One clock; reset is asynchronous and active-high.
- RST asserted: all residues c = 0, all Y_p = 0, all Y_m = 0, mode register = 0.
- Per element, each cycle with EN = 1:
  - Add mode: pos = a_p + b_p, neg = a_m + b_m.
  - Subtract mode: pos = a_p + b_m, neg = a_m + b_p.
  - net = pos - neg, range -2..2.
  - s = c + net, computed at CNT_W+2 bits.
- Output rule, registered, 1-cycle latency from inputs:
  - s >= 1: Y_p <= 1, Y_m <= 0, c_next = s - 1.
  - s <= -1: Y_p <= 0, Y_m <= 1, c_next = s + 1.
  - s == 0: both outputs 0, c_next = 0.
- Y_p and Y_m are never both 1.
- c_next saturates to the counter range. Excess is discarded (precision loss only).
- EN = 0: c holds, Y_p and Y_m are driven 0 for that cycle, mode register holds.
- Mode handling:
  - MODE is registered internally.
  - When MODE differs from the registered value while EN = 1, every residue is cleared (c_next = 0) that cycle.
  - The output for that cycle uses the new MODE with c treated as 0.
  - The registered mode then updates.
  - MODE changes while EN = 0 take effect at the next EN = 1 cycle, with the same clear.
- CLR = 1 (any EN): c <= 0, Y_p <= 0, Y_m <= 0. Inputs that cycle are discarded.
- Priority: RST > CLR > EN.
- All elements are independent; there is no cross-element interaction.
- Long-run mean of (Y_p - Y_m) equals the mean of (A ± B) per element while no saturation occurs.

Optional Feature:
- Macro: STOCH_ADDSUB_SAT_FLAG_EN.
- Defined:
  - Adds output SAT, width [NUM_ROWS][NUM_COLS]: per-element sticky flag.
  - SAT is set the cycle after c_next is clamped.
  - SAT is cleared by RST or CLR only; a mode-change clear does not clear it.
- Undefined: no SAT port, no flag logic. Behaviour is otherwise identical.

Decomposition:
- Package stoch_addsub_pkg:
  - Typedef stoch_mode_t, 1-bit enum: STOCH_ADD = 0, STOCH_SUB = 1.
  - Localparams CNT_MAX and CNT_MIN, computed by functions of CNT_W.
  - Function sat_clamp(s, CNT_W).
- Sub-module stoch_signed_addsub_elem:
  - One element: residue counter, output register, optional SAT.
  - Takes a shared mode_clr strobe generated once at the matrix level.
- Matrix top: generate loop over rows and cols, plus the shared mode register and mode-change detect.

Test Plan:
- Reset: RST pulsed mid-stream with c = 3 -> Y_p = Y_m = 0 immediately, c = 0; first EN cycle with all inputs 0 -> outputs stay 0.
- Add carry: MODE = 0; A_p = B_p = 1, others 0, for 4 cycles, then all inputs 0 for 4 cycles -> Y_p = 1 for 8 consecutive cycles, Y_m = 0, final c = 0.
- Subtract cancel: MODE = 1; A_p = B_p = 1 for 10 cycles -> Y_p = Y_m = 0 throughout. Then A_m = 1, B_p = 1 for 2 cycles -> Y_m = 1 for 4 cycles.
- Saturation (CNT_W = 4): MODE = 0; A_p = B_p = 1 for 12 cycles -> c clamps at 7; with the macro defined, SAT = 1 from the cycle after the first clamp. Inputs then 0 -> exactly 7 more Y_p = 1 cycles.
- Mode switch: c = 3 in add mode, MODE toggled to 1 with inputs 0 -> Y = 0 that cycle, c = 0, and no residual ones afterwards.
- Stall/clear: EN = 0 for 3 cycles with c = 2 -> outputs 0 and c held at 2; EN = 1 -> 2 Y_p pulses. CLR with EN = 1 -> c = 0 and inputs discarded.
